sd_sector_streamer: RTL and testbench
=====================================

Name: sd_sector_streamer

Overview:
- Sits directly around the SD sector reader, upstream and downstream of it.
- Issues sequential single-sector read commands (rstart/rsector) for a requested run of sectors.
- Captures the reader's byte output (outen/outaddr/outbyte) into a two-bank ping-pong buffer of 512 bytes per bank.
- Drains the buffer as a 32-bit valid/ready word stream toward the video pipeline, so sector N+1 is fetched while sector N drains.

Parameters:
- BUF_BANKS, 2, number of 512-byte sector banks; legal values 2 or 4 (power of two).

Ports:
- clk  input  1  system clock, same clock as the SD reader.
- rstn  input  1  asynchronous active-low reset; 0 = reset, 1 = working.
- start  input  1  one-cycle pulse; begins a run; ignored while busy=1.
- base_sector  input  32  first sector number; sampled on start.
- sector_count  input  32  number of sectors; sampled on start.
- busy  output  1  high from the cycle after an accepted start until the last word is accepted.
- done  output  1  one-cycle pulse when the last word of the run is accepted.
- rstart  output  1  read request to the SD reader.
- rsector  output  32  sector number to the SD reader.
- rbusy  input  1  SD reader busy (high during card init and while reading).
- rdone  input  1  SD reader one-cycle sector-complete pulse.
- inen  input  1  byte valid from the SD reader.
- inaddr  input  9  byte index 0..511 within the sector.
- inbyte  input  8  byte data.
- m_valid  output  1  stream word valid.
- m_ready  input  1  stream word ready.
- m_data  output  32  stream word, little-endian: byte 4k in [7:0] … byte 4k+3 in [31:24].

Behaviour:
- Reset values: busy=0, done=0, rstart=0, rsector=0, m_valid=0, m_data=0. Bank flags cleared; both FSMs return to IDLE.
- Reset is asynchronous: asserting rstn mid-run abandons the run immediately, with no done pulse. Bytes arriving after reset release while in IDLE are ignored.
- start with sector_count=0: busy stays 0; done pulses exactly one cycle after start.
- Fill FSM states:
  - IDLE → ISSUE on an accepted start.
  - ISSUE: wait until rbusy=0 and the write bank is empty. Then drive rstart=1 for exactly one cycle with rsector = base_sector + issued_count (32-bit wrap-around), and go to ACK.
  - ACK: wait for rbusy=1 (reader accepted the command), then go to FILL.
  - FILL: every cycle with inen=1, write inbyte to bank[wr_bank][inaddr]. Rewrites of the same address (reader internal retry) simply overwrite. On rdone=1, mark wr_bank full, advance wr_bank modulo BUF_BANKS, increment issued_count. If issued_count = sector_count go to IDLE, else go to ISSUE.
  - rstart is never asserted while rbusy=1. A reader still initialising simply stalls ISSUE indefinitely.
- Drain FSM:
  - When rd_bank is full, reads 128 words in order; word k = bytes 4k..4k+3.
  - Buffer RAM has 1-cycle read latency. m_data/m_valid are registered with a one-entry skid, so m_valid may stay high every cycle while m_ready=1: throughput 1 word/clk.
  - m_data is held stable and m_valid stays high until m_ready=1 (AXI-stream rules).
  - After word 127 of a bank is accepted, that bank is cleared and rd_bank advances. The cleared bank is writable the next cycle.
  - A single cycle may both accept word 127 of bank A and start filling bank B; banks are independent.
- done pulses in the cycle after the final word (word 127 of sector sector_count-1) is accepted; busy falls in that same cycle.
- Latency: first m_valid no earlier than 2 cycles after the first bank is marked full.
- Full: all banks full → ISSUE stalls, rstart is not asserted.
- Empty: no full bank → m_valid=0.

Optional Feature:
- Macro: SD_STREAM_LAST_EN.
- Defined: adds output port m_last (1 bit, reset 0), high together with m_valid on word 127 of every sector. Also adds output sector_idx (32 bits, reset 0), giving the run-relative index of the sector currently draining.
- Undefined: neither port exists; behaviour is otherwise identical.

Test Plan:
- Single sector: start, base_sector=100, sector_count=1, reader model returns bytes i&0xFF, m_ready=1 → one rstart with rsector=100. 128 words, first 0x03020100, last 0xFFFEFDFC. done pulses once; busy falls.
- Four sectors, base_sector=0xFFFFFFFE → rsector sequence 0xFFFFFFFE, 0xFFFFFFFF, 0x00000000, 0x00000001. 512 words in order; no rstart while rbusy=1.
- Backpressure: m_ready=0 for 2000 cycles with a 3-sector run, BUF_BANKS=2 → exactly 2 rstart pulses, then stall. m_data is stable while stalled. Releasing m_ready completes the run with the correct data.
- Reader retry: model rewrites addresses 0..40 with new values before rdone → the stream carries the second-pass values.
- Reader init stall: rbusy=1 for 5000 cycles after start → no rstart; first rstart occurs the cycle after rbusy falls.
- sector_count=0 → no rstart, done one cycle after start. Reset asserted mid-FILL → all outputs return to reset values immediately, and a new start afterwards runs cleanly.

Source files
------------

// File: rtl/sd_sector_streamer.sv
// Streams runs of SD sectors through a ping-pong bank buffer as 32-bit words.
// Define SD_STREAM_LAST_EN to add the m_last and sector_idx outputs.
module sd_sector_streamer #(
    parameter int BUF_BANKS = 2
) (
    input  logic        clk,
    input  logic        rstn,
    input  logic        start,
    input  logic [31:0] base_sector,
    input  logic [31:0] sector_count,
    output logic        busy,
    output logic        done,
    output logic        rstart,
    output logic [31:0] rsector,
    input  logic        rbusy,
    input  logic        rdone,
    input  logic        inen,
    input  logic [8:0]  inaddr,
    input  logic [7:0]  inbyte,
    output logic        m_valid,
    input  logic        m_ready,
    output logic [31:0] m_data
`ifdef SD_STREAM_LAST_EN
    ,
    output logic        m_last,
    output logic [31:0] sector_idx
`endif
);

    localparam int BW    = (BUF_BANKS > 1) ? $clog2(BUF_BANKS) : 1;
    localparam int DEPTH = BUF_BANKS * 128;

    typedef enum logic [1:0] {F_IDLE, F_ISSUE, F_ACK, F_FILL} fill_t;

    fill_t                fstate, fstate_nx;
    logic                 issue_go;
    logic [31:0]          base_q, count_q, issued;
    logic [BW-1:0]        wr_bank, iss_bank, acc_bank;
    logic [BUF_BANKS-1:0] full;
    logic [6:0]           iss_word, acc_word;
    logic [31:0]          acc_sec;
    logic                 p_valid, s_valid;
    logic [31:0]          ram_q, s_data;
    logic [3:0][7:0]      mem [DEPTH];
    logic [1:0]           occ;

    logic accept_start, run_go, zero_go;
    logic fill_evt, wr_en, rd_go;
    logic m_accept, last_word, last_run;

    assign accept_start = start && !busy;
    assign run_go       = accept_start && (sector_count != 32'd0);
    assign zero_go      = accept_start && (sector_count == 32'd0);
    assign wr_en        = (fstate == F_FILL) && inen;
    assign fill_evt     = (fstate == F_FILL) && rdone;

    // Room for one more read if, after this cycle's accept, at most one
    // word is still held in the output/skid registers or in flight.
    assign occ   = {1'b0, m_valid} + {1'b0, s_valid} + {1'b0, p_valid};
    assign rd_go = full[iss_bank] &&
                   ((occ < 2'd2) || ((occ == 2'd2) && m_accept));

    assign m_accept  = m_valid && m_ready;
    assign last_word = m_accept && (acc_word == 7'd127);
    assign last_run  = last_word && (acc_sec == count_q - 32'd1);

`ifdef SD_STREAM_LAST_EN
    assign m_last     = m_valid && (acc_word == 7'd127);
    assign sector_idx = acc_sec;
`endif

    // Fill FSM state register
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) fstate <= F_IDLE;
        else       fstate <= fstate_nx;
    end

    // Fill FSM next state and read-command decision
    always_comb begin
        fstate_nx = fstate;
        issue_go  = 1'b0;
        unique case (fstate)
            F_IDLE:  if (run_go) fstate_nx = F_ISSUE;
            F_ISSUE: if (!rbusy && !full[wr_bank]) begin
                issue_go  = 1'b1;
                fstate_nx = F_ACK;
            end
            F_ACK:   if (rbusy) fstate_nx = F_FILL;
            F_FILL:  if (rdone)
                fstate_nx = (issued + 32'd1 == count_q) ? F_IDLE : F_ISSUE;
            default: fstate_nx = F_IDLE;
        endcase
    end

    // Run parameters, command outputs and write-side bank pointer
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            rstart  <= 1'b0;
            rsector <= 32'd0;
            base_q  <= 32'd0;
            count_q <= 32'd0;
            issued  <= 32'd0;
            wr_bank <= '0;
        end else begin
            rstart <= issue_go;
            if (issue_go) rsector <= base_q + issued;
            if (run_go) begin
                base_q  <= base_sector;
                count_q <= sector_count;
                issued  <= 32'd0;
                wr_bank <= '0;
            end else if (fill_evt) begin
                issued  <= issued + 32'd1;
                wr_bank <= wr_bank + 1'b1;
            end
        end
    end

    // Bank full flags: set by the filler, cleared after the last word drains
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            full <= '0;
        end else begin
            if (last_word) full[acc_bank] <= 1'b0;
            if (fill_evt)  full[wr_bank]  <= 1'b1;
        end
    end

    // Sector buffer: byte-lane writes, one-cycle word reads
    always_ff @(posedge clk) begin
        if (wr_en) mem[{wr_bank, inaddr[8:2]}][inaddr[1:0]] <= inbyte;
        if (rd_go) ram_q <= mem[{iss_bank, iss_word}];
    end

    // Drain: read issue, output register with skid, acceptance tracking
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            p_valid  <= 1'b0;
            s_valid  <= 1'b0;
            s_data   <= 32'd0;
            m_valid  <= 1'b0;
            m_data   <= 32'd0;
            iss_word <= 7'd0;
            iss_bank <= '0;
            acc_word <= 7'd0;
            acc_bank <= '0;
            acc_sec  <= 32'd0;
        end else begin
            p_valid <= rd_go;
            if (rd_go) begin
                iss_word <= iss_word + 7'd1;
                if (iss_word == 7'd127) iss_bank <= iss_bank + 1'b1;
            end
            if (!m_valid || m_ready) begin
                if (s_valid) begin
                    m_valid <= 1'b1;
                    m_data  <= s_data;
                    s_valid <= p_valid;
                    s_data  <= ram_q;
                end else begin
                    m_valid <= p_valid;
                    if (p_valid) m_data <= ram_q;
                end
            end else if (p_valid) begin
                s_valid <= 1'b1;
                s_data  <= ram_q;
            end
            if (m_accept) begin
                acc_word <= acc_word + 7'd1;
                if (acc_word == 7'd127) begin
                    acc_bank <= acc_bank + 1'b1;
                    acc_sec  <= acc_sec + 32'd1;
                end
            end
            if (run_go) begin
                iss_word <= 7'd0;
                iss_bank <= '0;
                acc_word <= 7'd0;
                acc_bank <= '0;
                acc_sec  <= 32'd0;
            end
        end
    end

    // Run status: busy across a run, done one cycle after the final accept
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            busy <= 1'b0;
            done <= 1'b0;
        end else begin
            done <= zero_go || last_run;
            if (run_go)        busy <= 1'b1;
            else if (last_run) busy <= 1'b0;
        end
    end

endmodule

// File: tb/tb_sd_sector_streamer.sv
// Bench for sd_sector_streamer: SD reader model, random sink, reference stream.
`timescale 1ns/1ps
module tb_sd_sector_streamer;

    logic        clk = 1'b0;
    logic        rstn = 1'b0;
    logic        start = 1'b0;
    logic [31:0] base_sector = 32'd0;
    logic [31:0] sector_count = 32'd0;
    logic        busy, done, rstart;
    logic [31:0] rsector;
    logic        rbusy, rbusy_m, init_stall;
    logic        rdone, inen;
    logic [8:0]  inaddr;
    logic [7:0]  inbyte;
    logic        m_valid, m_ready;
    logic [31:0] m_data;
`ifdef SD_STREAM_LAST_EN
    logic        m_last;
    logic [31:0] sector_idx;
`endif

    assign rbusy = rbusy_m | init_stall;

    sd_sector_streamer #(.BUF_BANKS(2)) dut (
        .clk(clk), .rstn(rstn), .start(start),
        .base_sector(base_sector), .sector_count(sector_count),
        .busy(busy), .done(done), .rstart(rstart), .rsector(rsector),
        .rbusy(rbusy), .rdone(rdone), .inen(inen), .inaddr(inaddr),
        .inbyte(inbyte), .m_valid(m_valid), .m_ready(m_ready),
        .m_data(m_data)
`ifdef SD_STREAM_LAST_EN
        , .m_last(m_last), .sector_idx(sector_idx)
`endif
    );

    always #5 clk = ~clk;

    int          n_checks = 0;
    int          n_err = 0;
    int          g_mode = 0;
    bit          g_retry = 1'b0;
    int          g_rdy = 100;
    logic [31:0] issued_q[$];
    logic [31:0] got_q[$];
    int          viol = 0;
    int          stab_err = 0;
    int          done_cnt = 0;

    typedef struct {
        logic [31:0] base;
        int          n;
        int          mode;
        bit          retry;
        int          rdy;
        logic [31:0] first;
        logic [31:0] last;
    } vec_t;

    vec_t vecs[3];

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // Byte the reader returns for sector sec, index i, on a given pass
    function automatic logic [7:0] pat(input logic [31:0] sec, input int i,
                                       input int mode, input bit pass);
        logic [31:0] v;
        v = 32'(i) + ((mode != 0) ? sec * 32'd13 : 32'd0) +
            (pass ? 32'h55 : 32'h0);
        return v[7:0];
    endfunction

    // Reference word: last-written value of each of the four bytes
    function automatic logic [31:0] exp_word(input logic [31:0] sec,
                                             input int k);
        logic [31:0] w;
        for (int j = 0; j < 4; j++)
            w[8*j +: 8] = pat(sec, 4*k + j, g_mode,
                              g_retry && (4*k + j) <= 40);
        return w;
    endfunction

    // SD reader model
    initial begin
        logic [31:0] sec;
        rbusy_m = 1'b0; init_stall = 1'b0;
        rdone = 1'b0; inen = 1'b0; inaddr = 9'd0; inbyte = 8'd0;
        forever begin
            @(negedge clk);
            if (rstart) begin
                sec = rsector;
                issued_q.push_back(sec);
                @(posedge clk); #1 rbusy_m = 1'b1;
                repeat (2) @(posedge clk);
                #1;
                for (int i = 0; i < 512 && rstn; i++) begin
                    if ($urandom_range(0, 7) == 0) begin
                        inen = 1'b0;
                        @(posedge clk); #1;
                    end
                    inen = 1'b1; inaddr = 9'(i);
                    inbyte = pat(sec, i, g_mode, 1'b0);
                    @(posedge clk); #1;
                end
                if (g_retry) begin
                    for (int i = 0; i <= 40 && rstn; i++) begin
                        inen = 1'b1; inaddr = 9'(i);
                        inbyte = pat(sec, i, g_mode, 1'b1);
                        @(posedge clk); #1;
                    end
                end
                inen = 1'b0;
                if (rstn) begin
                    rdone = 1'b1;
                    @(posedge clk); #1 rdone = 1'b0;
                end
                rbusy_m = 1'b0;
            end
        end
    end

    // Random sink ready
    initial begin
        m_ready = 1'b0;
        forever begin
            @(posedge clk); #1;
            m_ready = int'($urandom_range(0, 99)) < g_rdy;
        end
    end

    // Stream capture and protocol monitors
    initial begin
        logic pv, pr, prs;
        logic [31:0] pd;
        pv = 1'b0; pr = 1'b0; prs = 1'b0; pd = 32'd0;
        forever begin
            @(negedge clk);
            if (rstn) begin
                if (m_valid && m_ready) got_q.push_back(m_data);
                if (rstart && (rbusy || prs)) viol++;
                if (pv && !pr && (!m_valid || m_data !== pd)) stab_err++;
                if (done) done_cnt++;
            end
            pv = m_valid; pr = m_ready; pd = m_data; prs = rstart;
        end
    end

    initial begin
        #900_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    task automatic start_run(input logic [31:0] b, input logic [31:0] n);
        got_q.delete(); issued_q.delete(); done_cnt = 0;
        @(posedge clk); #1;
        base_sector = b; sector_count = n; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    task automatic finish_run(input logic [31:0] b, input int n,
                              input string nm);
        int cyc, bad;
        bit seen;
        cyc = 0; seen = 1'b0;
        while (!seen && cyc < 4000*n + 3000) begin
            @(negedge clk);
            cyc++;
            if (done) begin
                seen = 1'b1;
                chk({nm, "_busy_at_done"}, busy, 0);
            end
        end
        chk({nm, "_done_seen"}, seen, 1);
        repeat (3) @(negedge clk);
        #1;
        chk({nm, "_done_pulses"}, done_cnt, 1);
        chk({nm, "_words"}, got_q.size(), 128*n);
        bad = 0;
        for (int k = 0; k < got_q.size() && k < 128*n; k++)
            if (got_q[k] !== exp_word(b + 32'(k/128), k % 128)) bad++;
        chk({nm, "_data_bad"}, bad, 0);
        chk({nm, "_rstarts"}, issued_q.size(), n);
        bad = 0;
        for (int s = 0; s < issued_q.size(); s++)
            if (issued_q[s] !== b + 32'(s)) bad++;
        chk({nm, "_rsector_seq"}, bad, 0);
    endtask

    initial begin
        int cyc, rs_seen;
        logic [31:0] rb;
        int rn;

        vecs[0] = '{32'd100, 1, 0, 1'b0, 100, 32'h03020100, 32'hFFFEFDFC};
        vecs[1] = '{32'hFFFFFFFE, 4, 1, 1'b0, 100,
                    32'hE9E8E7E6, 32'h0C0B0A09};
        vecs[2] = '{32'd7, 2, 1, 1'b1, 60, 32'hB3B2B1B0, 32'h67666564};

        repeat (3) @(negedge clk);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_rstart", rstart, 0);
        chk("rst_rsector", rsector, 0);
        chk("rst_m_valid", m_valid, 0);
        chk("rst_m_data", m_data, 0);
        @(posedge clk); #1 rstn = 1'b1;

        for (int v = 0; v < 3; v++) begin
            g_mode = vecs[v].mode; g_retry = vecs[v].retry;
            g_rdy = vecs[v].rdy;
            start_run(vecs[v].base, 32'(vecs[v].n));
            finish_run(vecs[v].base, vecs[v].n, $sformatf("vec%0d", v));
            chk($sformatf("vec%0d_first", v),
                got_q.size() > 0 ? got_q[0] : 32'hx, vecs[v].first);
            chk($sformatf("vec%0d_last", v),
                got_q.size() > 0 ? got_q[got_q.size()-1] : 32'hx,
                vecs[v].last);
        end

        for (int r = 0; r < 3; r++) begin
            rb = $urandom;
            rn = int'($urandom_range(1, 3));
            g_mode = 1; g_retry = 1'($urandom_range(0, 1));
            g_rdy = int'($urandom_range(20, 100));
            start_run(rb, 32'(rn));
            finish_run(rb, rn, $sformatf("rand%0d", r));
        end

        // sector_count = 0
        g_rdy = 100; g_retry = 1'b0;
        got_q.delete(); issued_q.delete();
        @(posedge clk); #1;
        base_sector = 32'd5; sector_count = 32'd0; start = 1'b1;
        @(negedge clk);
        chk("zero_done_early", done, 0);
        @(posedge clk); #1 start = 1'b0;
        @(negedge clk);
        chk("zero_done", done, 1);
        chk("zero_busy", busy, 0);
        @(negedge clk);
        chk("zero_done_once", done, 0);
        repeat (20) @(negedge clk);
        chk("zero_rstarts", issued_q.size(), 0);

        // Backpressure with two banks
        g_mode = 1; g_rdy = 0;
        start_run(32'd500, 32'd3);
        repeat (2000) @(negedge clk);
        #1;
        chk("bp_rstarts_stalled", issued_q.size(), 2);
        chk("bp_m_valid", m_valid, 1);
        chk("bp_m_data", m_data, exp_word(32'd500, 0));
        chk("bp_busy", busy, 1);
        g_rdy = 100;
        finish_run(32'd500, 3, "bp");

        // Reader still initialising
        init_stall = 1'b1;
        start_run(32'd42, 32'd1);
        rs_seen = 0;
        repeat (5000) begin
            @(negedge clk);
            if (rstart) rs_seen++;
        end
        chk("stall_no_rstart", rs_seen, 0);
        @(posedge clk); #1 init_stall = 1'b0;
        @(negedge clk);
        chk("stall_rstart_same_cycle", rstart, 0);
        @(negedge clk);
        chk("stall_rstart_next_cycle", rstart, 1);
        chk("stall_rsector", rsector, 32'd42);
        finish_run(32'd42, 1, "stall");

        // Reset in the middle of FILL
        start_run(32'd900, 32'd2);
        cyc = 0;
        while (!inen && cyc < 200) begin
            @(negedge clk);
            cyc++;
        end
        chk("mid_fill_reached", inen, 1);
        repeat (60) @(posedge clk);
        #3;
        chk("mid_busy_before", busy, 1);
        rstn = 1'b0;
        #1;
        chk("mid_rst_busy", busy, 0);
        chk("mid_rst_done", done, 0);
        chk("mid_rst_rstart", rstart, 0);
        chk("mid_rst_rsector", rsector, 0);
        chk("mid_rst_m_valid", m_valid, 0);
        chk("mid_rst_m_data", m_data, 0);
        repeat (3) @(posedge clk);
        #1 rstn = 1'b1;
        repeat (10) @(negedge clk);
        chk("post_rst_idle_busy", busy, 0);
        chk("post_rst_idle_valid", m_valid, 0);
        g_mode = 1; g_retry = 1'b1; g_rdy = 80;
        start_run(32'd77, 32'd2);
        finish_run(32'd77, 2, "post_reset");

        chk("rstart_protocol", viol, 0);
        chk("stream_stable", stab_err, 0);

        $display("Simulation finished: %0d checks, %0d errors",
                 n_checks, n_err);
        $finish;
    end

endmodule
